// File: rtl/perceptron_bpred.sv
// Perceptron branch predictor with a direct-mapped BTB. Each fetch PC yields one
// registered pbp_t record; resolved branches on the update port train weights, BTB and GHR.
package pbp_types;
  typedef struct packed {
    logic [7:0]  y_out;
    logic        bp_br_en;
    logic [31:0] bp_target;
  } pbp_t;
endpackage

module perceptron_bpred
  import pbp_types::*;
#(
  parameter int NUM_PERC = 32,
  parameter int HIST_LEN = 8,
  parameter int WEIGHT_W = 8,
  parameter int THETA    = 29
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic        if_stall,
  input  logic [31:0] if_pc,
  output logic        pbp_valid,
  output pbp_t        pbp,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic [7:0]  upd_y_out
);
  localparam int IDX_W = $clog2(NUM_PERC);
  localparam int TAG_W = 32 - IDX_W - 2;
  localparam int Y_W   = WEIGHT_W + $clog2(HIST_LEN + 1) + 1;
  localparam logic signed [Y_W-1:0] Y_MAX = 127;
  localparam logic signed [Y_W-1:0] Y_MIN = -128;
  localparam logic [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};

  logic [WEIGHT_W-1:0] weights [NUM_PERC][HIST_LEN+1];
  logic [HIST_LEN-1:0] ghr;
  logic [NUM_PERC-1:0] btb_valid;
  logic [TAG_W-1:0]    btb_tag    [NUM_PERC];
  logic [31:0]         btb_target [NUM_PERC];

  function automatic logic signed [Y_W-1:0] sext_w(input logic [WEIGHT_W-1:0] w);
    return {{(Y_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
  endfunction

  function automatic logic [WEIGHT_W-1:0] sat_step(input logic [WEIGHT_W-1:0] w,
                                                   input logic up);
    logic [WEIGHT_W-1:0] r;
    r = w;
    if (up && w != W_MAX)       r = w + WEIGHT_W'(1);
    else if (!up && w != W_MIN) r = w - WEIGHT_W'(1);
    return r;
  endfunction

  // Prediction: reads pre-update state, so a same-cycle update is never bypassed.
  logic [IDX_W-1:0]      rd_idx;
  logic signed [Y_W-1:0] y_sum;
  logic                  hit;
  pbp_t                  pred;

  assign rd_idx = if_pc[IDX_W+1:2];
  assign hit    = btb_valid[rd_idx] && (btb_tag[rd_idx] == if_pc[31:IDX_W+2]);

  always_comb begin
    y_sum = sext_w(weights[rd_idx][0]);
    for (int i = 1; i <= HIST_LEN; i++) begin
      if (ghr[i-1]) y_sum = y_sum + sext_w(weights[rd_idx][i]);
      else          y_sum = y_sum - sext_w(weights[rd_idx][i]);
    end
  end

  always_comb begin
    pred = '0;
    if (y_sum > Y_MAX)      pred.y_out = 8'h7f;
    else if (y_sum < Y_MIN) pred.y_out = 8'h80;
    else                    pred.y_out = y_sum[7:0];
    pred.bp_br_en  = !y_sum[Y_W-1] && hit;
    pred.bp_target = hit ? btb_target[rd_idx] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pbp_valid <= 1'b0;
      pbp       <= '0;
    end else if (!if_stall) begin
      pbp_valid <= if_req;
      if (if_req) pbp <= pred;
    end
  end

  // Training decision; |-128| must come out as 128, hence the 9-bit magnitude.
  logic [IDX_W-1:0] wr_idx;
  logic [8:0]       y_mag;
  logic             pred_taken;
  logic             do_train;

  assign wr_idx     = upd_pc[IDX_W+1:2];
  assign pred_taken = !upd_y_out[7];
  assign y_mag      = upd_y_out[7] ? (9'd256 - {1'b0, upd_y_out}) : {1'b0, upd_y_out};
  assign do_train   = (pred_taken != upd_taken) || (y_mag <= 9'(THETA));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr       <= '0;
      btb_valid <= '0;
      for (int p = 0; p < NUM_PERC; p++)
        for (int i = 0; i <= HIST_LEN; i++)
          weights[p][i] <= '0;
    end else if (upd_valid) begin
      ghr <= {ghr[HIST_LEN-2:0], upd_taken};
      if (do_train) begin
        weights[wr_idx][0] <= sat_step(weights[wr_idx][0], upd_taken);
        for (int i = 1; i <= HIST_LEN; i++)
          weights[wr_idx][i] <= sat_step(weights[wr_idx][i], upd_taken == ghr[i-1]);
      end
      if (upd_taken) btb_valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/target need no reset: they are qualified by btb_valid.
  always_ff @(posedge clk) begin
    if (rst_n && upd_valid && upd_taken) begin
      btb_tag[wr_idx]    <= upd_pc[31:IDX_W+2];
      btb_target[wr_idx] <= upd_target;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};
endmodule

// File: tb/tb_perceptron_bpred.sv
// Directed bench for perceptron_bpred: a vector table of update/request scenarios
// with hand-computed predictions, plus reset, stall and same-cycle sequences.
module tb_perceptron_bpred;
  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req;
  logic              if_stall;
  logic [31:0]       if_pc;
  logic              pbp_valid;
  pbp_types::pbp_t   pbp;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic [7:0]        upd_y_out;

  int tests = 0;
  int fails = 0;

  perceptron_bpred dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_stall   (if_stall),
    .if_pc      (if_pc),
    .pbp_valid  (pbp_valid),
    .pbp        (pbp),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .upd_y_out  (upd_y_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          rst;
    int          n_upd;
    logic [31:0] u_pc;
    logic        u_taken;
    logic [31:0] u_tgt;
    logic [7:0]  u_y;
    logic [31:0] req_pc;
    logic [7:0]  exp_y;
    logic        exp_en;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(bit rst, int n, logic [31:0] upc, logic tk, logic [31:0] tgt,
                              logic [7:0] uy, logic [31:0] rpc, logic [7:0] ey,
                              logic een, logic [31:0] etgt);
    vec_t v;
    v.rst = rst; v.n_upd = n; v.u_pc = upc; v.u_taken = tk; v.u_tgt = tgt; v.u_y = uy;
    v.req_pc = rpc; v.exp_y = ey; v.exp_en = een; v.exp_tgt = etgt;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_pbp(input string name, input logic v, input logic [7:0] y,
                           input logic en, input logic [31:0] tgt);
    check({name, "_valid"}, 64'(pbp_valid), 64'(v));
    check({name, "_y"}, 64'(pbp.y_out), 64'(y));
    check({name, "_en"}, 64'(pbp.bp_br_en), 64'(en));
    check({name, "_tgt"}, 64'(pbp.bp_target), 64'(tgt));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; if_req = 1'b0; upd_valid = 1'b0; if_stall = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v, input int k);
    if (v.rst) do_reset();
    for (int r = 0; r < v.n_upd; r++) begin
      upd_valid = 1'b1; upd_pc = v.u_pc; upd_taken = v.u_taken;
      upd_target = v.u_tgt; upd_y_out = v.u_y;
      step();
    end
    upd_valid = 1'b0;
    if_req = 1'b1; if_pc = v.req_pc;
    step();
    if_req = 1'b0;
    check_pbp($sformatf("vec%0d", k), 1'b1, v.exp_y, v.exp_en, v.exp_tgt);
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_stall = 1'b0; if_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_y_out = '0;

    // Cold-start prediction, trained taken, mispredict retrain, threshold edges,
    // saturation, negative y, aliasing tag miss, index isolation, |-128| handling.
    vecs[0]  = mk(1, 0,   32'h100, 1'b1, 32'h200, 8'd0,   32'h060, 8'h00, 1'b0, 32'h0);
    vecs[1]  = mk(1, 1,   32'h100, 1'b1, 32'h200, 8'd0,   32'h100, 8'h07, 1'b1, 32'h200);
    vecs[2]  = mk(0, 1,   32'h100, 1'b0, 32'h0,   8'd7,   32'h100, 8'h02, 1'b1, 32'h200);
    vecs[3]  = mk(1, 1,   32'h100, 1'b1, 32'h200, 8'd50,  32'h100, 8'h00, 1'b1, 32'h200);
    vecs[4]  = mk(1, 1,   32'h100, 1'b1, 32'h200, 8'd29,  32'h100, 8'h07, 1'b1, 32'h200);
    vecs[5]  = mk(1, 1,   32'h100, 1'b1, 32'h200, 8'd30,  32'h100, 8'h00, 1'b1, 32'h200);
    vecs[6]  = mk(1, 130, 32'h100, 1'b1, 32'h200, 8'd0,   32'h100, 8'h7f, 1'b1, 32'h200);
    vecs[7]  = mk(1, 1,   32'h100, 1'b0, 32'h0,   8'd0,   32'h100, 8'hf7, 1'b0, 32'h0);
    vecs[8]  = mk(1, 1,   32'h100, 1'b1, 32'h200, 8'd0,   32'h180, 8'h07, 1'b0, 32'h0);
    vecs[9]  = mk(1, 1,   32'h104, 1'b1, 32'h200, 8'd0,   32'h100, 8'h00, 1'b0, 32'h0);
    vecs[10] = mk(1, 1,   32'h100, 1'b0, 32'h0,   8'h80,  32'h100, 8'h00, 1'b0, 32'h0);
    vecs[11] = mk(1, 1,   32'h100, 1'b1, 32'h200, 8'h9c,  32'h100, 8'h07, 1'b1, 32'h200);

    step(); step();
    check_pbp("reset", 1'b0, 8'h00, 1'b0, 32'h0);

    // Reset with a concurrent request and update: both are dropped.
    if_req = 1'b1; if_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200; upd_y_out = 8'd0;
    step();
    check_pbp("rst_override", 1'b0, 8'h00, 1'b0, 32'h0);
    rst_n = 1'b1; upd_valid = 1'b0;
    step();
    if_req = 1'b0;
    check_pbp("rst_discard", 1'b1, 8'h00, 1'b0, 32'h0);

    for (int k = 0; k < 12; k++) apply_vec(vecs[k], k);

    // Output holds 7/taken/0x200 from the last vector; stall must freeze it.
    if_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if_req = c[0] ? 1'b0 : 1'b1;
      if_pc = 32'h60 + 32'(c * 4);
      step();
      check_pbp($sformatf("stall%0d", c), 1'b1, 8'h07, 1'b1, 32'h200);
    end
    if_stall = 1'b0; if_req = 1'b0;
    step();
    check("idle_valid", 64'(pbp_valid), 64'd0);

    // Same-cycle request and update at index 0: capture sees pre-update state.
    do_reset();
    if_req = 1'b1; if_pc = 32'h80;
    upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1; upd_target = 32'h300; upd_y_out = 8'd0;
    step();
    upd_valid = 1'b0;
    check_pbp("same_cyc", 1'b1, 8'h00, 1'b0, 32'h0);
    step();
    if_req = 1'b0;
    check_pbp("after_same", 1'b1, 8'h07, 1'b1, 32'h300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
